// File: rtl/alarm_pkg.sv
// Shared types and defaults for the vehicle alarm controller.
// Also provides the duration saturation helper used by the parameter block.
package alarm_pkg;

    localparam logic [2:0] ST_ARMED      = 3'd0;
    localparam logic [2:0] ST_ENTRY_WAIT = 3'd1;
    localparam logic [2:0] ST_ALARM      = 3'd2;
    localparam logic [2:0] ST_ALARM_HOLD = 3'd3;
    localparam logic [2:0] ST_DISARMED   = 3'd4;
    localparam logic [2:0] ST_EXIT_WAIT  = 3'd5;
    localparam logic [2:0] ST_EXIT_DOOR  = 3'd6;
    localparam logic [2:0] ST_ARM_WAIT   = 3'd7;

    typedef enum logic [2:0] {
        ARMED      = ST_ARMED,
        ENTRY_WAIT = ST_ENTRY_WAIT,
        ALARM      = ST_ALARM,
        ALARM_HOLD = ST_ALARM_HOLD,
        DISARMED   = ST_DISARMED,
        EXIT_WAIT  = ST_EXIT_WAIT,
        EXIT_DOOR  = ST_EXIT_DOOR,
        ARM_WAIT   = ST_ARM_WAIT
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARM       = 2'd0,
        SEL_DRIVER    = 2'd1,
        SEL_PASSENGER = 2'd2,
        SEL_ALARM_ON  = 2'd3
    } param_sel_t;

    localparam int DEF_T_ARM_DELAY       = 6;
    localparam int DEF_T_DRIVER_DELAY    = 8;
    localparam int DEF_T_PASSENGER_DELAY = 15;
    localparam int DEF_T_ALARM_ON        = 10;

    // The timer never expires when loaded with zero, so zero becomes one.
    function automatic logic [3:0] sat_dur(input logic [3:0] v);
        return (v == 4'd0) ? 4'd1 : v;
    endfunction

endpackage

// File: rtl/alarm_time_params.sv
// Countdown duration selection for the alarm controller.
// With ALARM_REPROG_EN defined the four durations live in runtime registers.
module alarm_time_params
    import alarm_pkg::*;
#(
    parameter int T_ARM_DELAY       = DEF_T_ARM_DELAY,
    parameter int T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
    parameter int T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
    parameter int T_ALARM_ON        = DEF_T_ALARM_ON
) (
`ifdef ALARM_REPROG_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  param_sel_t wr_sel_i,
    input  logic [3:0] wr_val_i,
`endif
    input  param_sel_t sel_i,
    output logic [3:0] duration_o
);

    if (T_ARM_DELAY < 0 || T_ARM_DELAY > 15) begin : g_bad_arm
        $error("T_ARM_DELAY must fit in 4 bits");
    end
    if (T_DRIVER_DELAY < 0 || T_DRIVER_DELAY > 15) begin : g_bad_drv
        $error("T_DRIVER_DELAY must fit in 4 bits");
    end
    if (T_PASSENGER_DELAY < 0 || T_PASSENGER_DELAY > 15) begin : g_bad_pas
        $error("T_PASSENGER_DELAY must fit in 4 bits");
    end
    if (T_ALARM_ON < 0 || T_ALARM_ON > 15) begin : g_bad_aon
        $error("T_ALARM_ON must fit in 4 bits");
    end

    localparam logic [3:0] DUR_ARM = sat_dur(4'(T_ARM_DELAY));
    localparam logic [3:0] DUR_DRV = sat_dur(4'(T_DRIVER_DELAY));
    localparam logic [3:0] DUR_PAS = sat_dur(4'(T_PASSENGER_DELAY));
    localparam logic [3:0] DUR_AON = sat_dur(4'(T_ALARM_ON));

`ifdef ALARM_REPROG_EN
    logic [3:0] dur_q [4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dur_q[SEL_ARM]       <= DUR_ARM;
            dur_q[SEL_DRIVER]    <= DUR_DRV;
            dur_q[SEL_PASSENGER] <= DUR_PAS;
            dur_q[SEL_ALARM_ON]  <= DUR_AON;
        end else if (wr_en_i) begin
            dur_q[wr_sel_i] <= sat_dur(wr_val_i);
        end
    end

    assign duration_o = dur_q[sel_i];
`else
    always_comb begin
        case (sel_i)
            SEL_ARM:       duration_o = DUR_ARM;
            SEL_DRIVER:    duration_o = DUR_DRV;
            SEL_PASSENGER: duration_o = DUR_PAS;
            default:       duration_o = DUR_AON;
        endcase
    end
`endif

endmodule

// File: rtl/alarm_controller.sv
// Anti-theft sequencing FSM driving the countdown timer, siren and status LED.
// Define ALARM_REPROG_EN to add runtime-programmable durations.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int T_ARM_DELAY       = DEF_T_ARM_DELAY,
    parameter int T_DRIVER_DELAY    = DEF_T_DRIVER_DELAY,
    parameter int T_PASSENGER_DELAY = DEF_T_PASSENGER_DELAY,
    parameter int T_ALARM_ON        = DEF_T_ALARM_ON
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ignition,
    input  logic       door_driver,
    input  logic       door_pass,
    input  logic       timer_expired,
    input  logic       timer_tick,
`ifdef ALARM_REPROG_EN
    input  logic       reprogram,
    input  logic [1:0] param_sel,
    input  logic [3:0] param_val,
`endif
    output logic       timer_start,
    output logic [3:0] timer_duration,
    output logic       siren,
    output logic       status_led,
    output logic [2:0] state_o
);

    state_t     state_q, state_d;
    logic       start_q, start_d;
    logic [3:0] dur_q, dur_d;
    logic       siren_q, siren_d;
    logic       led_q, led_d;
    param_sel_t sel;
    logic [3:0] sel_dur;
    logic       any_door;
    logic       exp_ok;

`ifdef ALARM_REPROG_EN
    logic wr_en;
    assign wr_en = reprogram && (state_q == DISARMED || state_q == EXIT_WAIT);
`endif

    alarm_time_params #(
        .T_ARM_DELAY      (T_ARM_DELAY),
        .T_DRIVER_DELAY   (T_DRIVER_DELAY),
        .T_PASSENGER_DELAY(T_PASSENGER_DELAY),
        .T_ALARM_ON       (T_ALARM_ON)
    ) u_params (
`ifdef ALARM_REPROG_EN
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_sel_i  (param_sel_t'(param_sel)),
        .wr_val_i  (param_val),
`endif
        .sel_i     (sel),
        .duration_o(sel_dur)
    );

    assign any_door = door_driver | door_pass;
    // The level seen while our own start is in flight still belongs to the old countdown.
    assign exp_ok   = timer_expired & ~start_q;

    always_comb begin
        state_d = state_q;
        start_d = 1'b0;
        sel     = SEL_ALARM_ON;
        if (ignition && state_q != DISARMED) begin
            state_d = DISARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (door_driver) begin
                        state_d = ENTRY_WAIT;
                        start_d = 1'b1;
                        sel     = SEL_DRIVER;
                    end else if (door_pass) begin
                        state_d = ENTRY_WAIT;
                        start_d = 1'b1;
                        sel     = SEL_PASSENGER;
                    end
                end
                ENTRY_WAIT: if (exp_ok) state_d = ALARM;
                ALARM: begin
                    if (!any_door) begin
                        state_d = ALARM_HOLD;
                        start_d = 1'b1;
                        sel     = SEL_ALARM_ON;
                    end
                end
                ALARM_HOLD: begin
                    if (any_door)    state_d = ALARM;
                    else if (exp_ok) state_d = ARMED;
                end
                DISARMED:  if (!ignition) state_d = EXIT_WAIT;
                EXIT_WAIT: if (door_driver) state_d = EXIT_DOOR;
                EXIT_DOOR: begin
                    if (!any_door) begin
                        state_d = ARM_WAIT;
                        start_d = 1'b1;
                        sel     = SEL_ARM;
                    end
                end
                ARM_WAIT: begin
                    if (any_door)    state_d = EXIT_DOOR;
                    else if (exp_ok) state_d = ARMED;
                end
                default: state_d = ARMED;
            endcase
        end
    end

    always_comb begin
        dur_d   = start_d ? sel_dur : dur_q;
        siren_d = (state_d == ALARM) || (state_d == ALARM_HOLD);
        case (state_d)
            // Blink restarts from off whenever ARMED is re-entered.
            ARMED:                         led_d = (state_q == ARMED) ? (led_q ^ timer_tick) : 1'b0;
            ENTRY_WAIT, ALARM, ALARM_HOLD: led_d = 1'b1;
            default:                       led_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARMED;
            start_q <= 1'b0;
            dur_q   <= 4'd0;
            siren_q <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            dur_q   <= dur_d;
            siren_q <= siren_d;
            led_q   <= led_d;
        end
    end

    assign timer_start    = start_q;
    assign timer_duration = dur_q;
    assign siren          = siren_q;
    assign status_led     = led_q;
    assign state_o        = state_q;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Anti-theft sequencing FSM.
- Initiator side of the countdown-timer interface: issues timer start/duration, consumes expired and the 1 Hz tick.
- Watches ignition and door switches; drives siren and status LED.
- Sits between debounced vehicle inputs and the timer block, one per vehicle.

Parameters:
- T_ARM_DELAY, 6, seconds from last door close to armed (1..15).
- T_DRIVER_DELAY, 8, entry grace after driver door opens while armed (1..15).
- T_PASSENGER_DELAY, 15, entry grace after passenger door opens while armed (1..15).
- T_ALARM_ON, 10, seconds siren persists after all doors close (1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ignition  in  1  ignition key on (debounced, synchronous to clk)
- door_driver  in  1  driver door open
- door_pass  in  1  any passenger door open
- timer_expired  in  1  countdown-timer expired level
- timer_tick  in  1  countdown-timer 1 Hz one-cycle pulse
- timer_start  out  1  one-cycle start request to timer
- timer_duration  out  4  seconds; valid in the start cycle, held afterwards
- siren  out  1  siren drive, registered
- status_led  out  1  status indicator, registered
- state_o  out  3  current state encoding, debug

Behaviour:
- Reset (rst=0): state ARMED, siren=0, status_led=0, timer_start=0, timer_duration=0. Async assert, synchronous deassert handled upstream.
- States: ARMED, ENTRY_WAIT, ALARM, ALARM_HOLD, DISARMED, EXIT_WAIT, EXIT_DOOR, ARM_WAIT.
- timer_start is asserted for exactly one cycle, on the transition edge into ENTRY_WAIT, ALARM_HOLD or ARM_WAIT; timer_duration is registered in the same edge.
- timer_expired is ignored in the cycle timer_start=1 and in any state that did not issue the current start; it is a stale level otherwise.
- ARMED: status_led toggles on each timer_tick; siren=0.
  - ignition=1 -> DISARMED.
  - door_driver=1 -> ENTRY_WAIT, duration T_DRIVER_DELAY (driver wins if both doors open same cycle).
  - Else door_pass=1 -> ENTRY_WAIT, duration T_PASSENGER_DELAY.
- ENTRY_WAIT: status_led=1 solid.
  - ignition=1 -> DISARMED (priority over expired in the same cycle).
  - timer_expired -> ALARM.
- ALARM: siren=1, status_led=1.
  - ignition=1 -> DISARMED.
  - All doors closed -> ALARM_HOLD, start T_ALARM_ON.
- ALARM_HOLD: siren=1.
  - ignition -> DISARMED.
  - Any door opens -> ALARM (the timer is not restarted until doors close again).
  - timer_expired -> ARMED, siren=0 next cycle.
- DISARMED: siren=0, status_led=0. ignition=0 -> EXIT_WAIT.
- EXIT_WAIT: ignition=1 -> DISARMED; driver door opens -> EXIT_DOOR.
- EXIT_DOOR: ignition=1 -> DISARMED; all doors closed -> ARM_WAIT, start T_ARM_DELAY.
- ARM_WAIT: ignition=1 -> DISARMED; any door opens -> EXIT_DOOR (no start); timer_expired -> ARMED.
- Priority within every state: ignition > door events > expired.
- Duration width rule: durations are 4-bit. Value 0 is saturated to 1, because the timer never expires on 0. Parameters > 15 are an elaboration error.
- Blink phase restarts with each timer_start, since the timer resets its tick divider.

Optional Feature:
- Macro ALARM_REPROG_EN.
- Defined: adds ports reprogram (1), param_sel (2: 0=arm, 1=driver, 2=passenger, 3=alarm_on) and param_val (4).
  - reprogram=1 for one cycle writes param_val (0 saturated to 1) into the selected runtime register.
  - Registers reset to the parameter defaults.
  - A write takes effect on the next timer_start; a running countdown is unaffected.
  - Writes are accepted only in DISARMED/EXIT_WAIT; they are ignored in other states.
- Undefined: durations are the constant parameters and the extra ports are absent.

Decomposition:
- Package alarm_pkg holds:
  - state_t enum (3-bit)
  - param_sel_t enum
  - default duration localparams
  - saturate-to-1 function
- Sub-module alarm_time_params: selects the duration from param_sel_t and holds the runtime registers under ALARM_REPROG_EN. The FSM remains in alarm_controller.

Test Plan:
- Reset then door_driver=1: one-cycle timer_start, timer_duration=8, state ENTRY_WAIT. Expired after 8 ticks -> siren=1 next cycle.
- ARMED, door_pass=1, ignition=1 at tick 5 -> DISARMED, siren never asserted. Same-cycle ignition+expired -> DISARMED.
- ALARM, close doors -> start with duration 10. Reopen at tick 4 -> ALARM, siren held. Close -> new start with 10. Expire -> ARMED, siren=0.
- DISARMED, ignition off, driver door open/close -> ARM_WAIT with duration 6. Reopen at tick 3 -> EXIT_DOOR. Close -> fresh start 6. Expire -> ARMED with LED toggling per tick.
- Stale expired: expired held 1 entering ENTRY_WAIT in the start cycle -> no ALARM transition.
- ALARM_REPROG_EN: write driver=0 in DISARMED -> stored 1. Next armed driver entry uses duration 1. A write attempted in ARMED is ignored.
